// File: rtl/sm_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package sm_imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/sm_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; first byte lands in bits [7:0].
module sm_word_packer
  import sm_imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

  logic [IdxW-1:0] idx_q;
  logic [31:0]     word_q;

  // Shifting in from the top leaves the oldest byte in the LSBs after a full word.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (strobe_i) begin
      idx_q  <= idx_q + IdxW'(1);
      word_q <= {byte_i, word_q[31:8]};
    end
  end

  assign word_o = word_q;
  assign last_o = (idx_q == IdxW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/sm_imem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM while holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by SM_IMEM_LOADER_CHECKSUM_EN.
module sm_imem_loader
  import sm_imem_loader_pkg::*;
#(
  parameter int unsigned SIZE   = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_rst_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [15:0] SizeW = 16'(SIZE);

  state_e            state_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              in_ready_q, wr_en_q, hold_q, busy_q, done_q, err_q;

  logic        accept, start_ok, pk_strobe, pk_last, last_word;
  logic [15:0] len_full, ptr_next;
  logic [31:0] pk_word;

  assign accept    = in_valid_i & in_ready_q;
  assign start_ok  = start_i & (state_q inside {StIdle, StDone, StErr});
  assign len_full  = {in_data_i, count_q[7:0]};
  assign ptr_next  = 16'(ptr_q) + 16'd1;
  assign last_word = (ptr_next == count_q);
  assign pk_strobe = accept & (state_q == StData);

  sm_word_packer u_packer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_ok),
    .strobe_i (pk_strobe),
    .byte_i   (in_data_i),
    .word_o   (pk_word),
    .last_o   (pk_last)
  );

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      xor_q <= '0;
    end else if (pk_strobe) begin
      xor_q <= xor_q ^ in_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ptr_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            state_q    <= StLen0;
            count_q    <= '0;
            ptr_q      <= '0;
            in_ready_q <= 1'b1;
            hold_q     <= 1'b1;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
          end
        end
        StLen0: begin
          if (accept) begin
            count_q[7:0] <= in_data_i;
            state_q      <= StLen1;
          end
        end
        StLen1: begin
          if (accept) begin
            count_q[15:8] <= in_data_i;
            if (len_full == 16'd0) begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
              state_q <= StCsum;
`else
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              hold_q     <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else if (len_full > SizeW) begin
              state_q    <= StErr;
              in_ready_q <= 1'b0;
              hold_q     <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept && pk_last) begin
            state_q    <= StWrite;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
          end
        end
        StWrite: begin
          if (last_word) begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
            state_q    <= StCsum;
            in_ready_q <= 1'b1;
`else
            state_q <= StDone;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            // Pointer only advances when another word follows, so it never passes count-1.
            ptr_q      <= ptr_next[ADDR_W-1:0];
            state_q    <= StData;
            in_ready_q <= 1'b1;
          end
        end
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
        StCsum: begin
          if (accept) begin
            state_q    <= StDone;
            in_ready_q <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= (xor_q != in_data_i);
          end
        end
`endif
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
          hold_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = ptr_q;
  assign wr_data_o      = pk_word;
  assign cpu_rst_hold_o = hold_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
